// File: rtl/cr_huf_comp_ht_sort_reader_pkg.sv
// Shared types for the sorter -> Huffman-tree table reader.
// Pipe end-of-block markers and reader state encoding.
package cr_huf_comp_ht_sort_reader_pkg;

  localparam int SEQID_WIDTH = 8;

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    EOB_MORE  = 2'd1,
    EOB_TRUE  = 2'd2,
    PASS_THRU = 2'd3
  } e_pipe_eob;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } e_ht_rd_state;

endpackage

// File: rtl/cr_huf_comp_ht_sort_reader.sv
// Captures a sorted freq/symbol table and streams the used entries,
// lowest frequency first, two per beat over a valid/ready port.
module cr_huf_comp_ht_sort_reader
  import cr_huf_comp_ht_sort_reader_pkg::*;
#(
  parameter int DAT_WIDTH        = 10,
  parameter int SYM_FREQ_WIDTH   = 15,
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [MAX_NUM_SYM_USED*SYM_FREQ_WIDTH-1:0] is_ht_sym_sort_freq,
  input  logic [MAX_NUM_SYM_USED*DAT_WIDTH-1:0]    is_ht_sym_sort_freq_sym,
  input  logic [DAT_WIDTH-1:0]                     is_ht_sym_unique,
  input  logic [DAT_WIDTH-1:0]                     is_ht_sym_lo,
  input  logic [DAT_WIDTH-1:0]                     is_ht_sym_hi,
  input  logic [CNTRL_WIDTH-1:0]                   is_ht_meta,
  input  logic [SEQID_WIDTH-1:0]                   is_ht_seq_id,
  input  e_pipe_eob                                is_ht_eob,
  output logic                                     ht_is_not_ready,
  output logic                                     rd_valid,
  input  logic                                     rd_ready,
  output logic [1:0][DAT_WIDTH-1:0]                rd_sym,
  output logic [1:0][SYM_FREQ_WIDTH-1:0]           rd_freq,
  output logic [1:0]                               rd_lane_vld,
  output logic                                     rd_first,
  output logic                                     rd_last,
  output e_pipe_eob                                rd_eob,
  output logic [CNTRL_WIDTH-1:0]                   rd_meta,
  output logic [SEQID_WIDTH-1:0]                   rd_seq_id,
  output logic [DAT_WIDTH-1:0]                     rd_sym_lo,
  output logic [DAT_WIDTH-1:0]                     rd_sym_hi,
  output logic                                     rd_err
);

  localparam int PW = DAT_WIDTH + 1;
  localparam logic [PW-1:0] MAXP = PW'(MAX_NUM_SYM_USED);

  e_ht_rd_state state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] uniq_q;
  logic [SYM_FREQ_WIDTH-1:0] freq_q [MAX_NUM_SYM_USED];
  logic [DAT_WIDTH-1:0]      sym_q  [MAX_NUM_SYM_USED];

  logic                                rd_valid_q;
  logic [1:0][DAT_WIDTH-1:0]           rd_sym_q;
  logic [1:0][SYM_FREQ_WIDTH-1:0]      rd_freq_q;
  logic [1:0]                          rd_lane_vld_q;
  logic                                rd_first_q;
  logic                                rd_last_q;
  e_pipe_eob                           rd_eob_q;
  logic [CNTRL_WIDTH-1:0]              rd_meta_q;
  logic [SEQID_WIDTH-1:0]              rd_seq_id_q;
  logic [DAT_WIDTH-1:0]                rd_sym_lo_q;
  logic [DAT_WIDTH-1:0]                rd_sym_hi_q;
  logic                                rd_err_q;

  logic          capture;
  logic          cg_en;
  logic          fire;
  logic [PW-1:0] uniq_c;
  logic [PW-1:0] sel_ptr;
  logic [PW-1:0] sel_ptr1;
  logic [1:0][DAT_WIDTH-1:0]      nxt_sym;
  logic [1:0][SYM_FREQ_WIDTH-1:0] nxt_freq;
  logic [1:0]                     nxt_vld;

  assign capture  = (state_q == IDLE) && (is_ht_eob != MIDDLE);
  assign cg_en    = capture || (state_q != IDLE) || rd_err_q;
  assign fire     = rd_valid_q && rd_ready;
  assign uniq_c   = ({1'b0, is_ht_sym_unique} > MAXP) ? MAXP
                  : {1'b0, is_ht_sym_unique};
  // Address the beat being loaded: current ptr, or the next pair on accept.
  assign sel_ptr  = rd_valid_q ? ptr_q + PW'(2) : ptr_q;
  assign sel_ptr1 = sel_ptr + PW'(1);

  always_comb begin
    nxt_sym  = '0;
    nxt_freq = '0;
    nxt_vld  = {sel_ptr1 < MAXP, sel_ptr < MAXP};
    if (nxt_vld[0]) begin
      nxt_sym[0]  = sym_q[sel_ptr[DAT_WIDTH-1:0]];
      nxt_freq[0] = freq_q[sel_ptr[DAT_WIDTH-1:0]];
    end
    if (nxt_vld[1]) begin
      nxt_sym[1]  = sym_q[sel_ptr1[DAT_WIDTH-1:0]];
      nxt_freq[1] = freq_q[sel_ptr1[DAT_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      uniq_q        <= '0;
      for (int i = 0; i < MAX_NUM_SYM_USED; i++) begin
        freq_q[i] <= '0;
        sym_q[i]  <= '0;
      end
      rd_valid_q    <= 1'b0;
      rd_sym_q      <= '0;
      rd_freq_q     <= '0;
      rd_lane_vld_q <= '0;
      rd_first_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_eob_q      <= MIDDLE;
      rd_meta_q     <= '0;
      rd_seq_id_q   <= '0;
      rd_sym_lo_q   <= '0;
      rd_sym_hi_q   <= '0;
      rd_err_q      <= 1'b0;
    end else if (cg_en) begin
      rd_err_q <= (state_q != IDLE) && (is_ht_eob != MIDDLE);
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < MAX_NUM_SYM_USED; i++) begin
              freq_q[i] <= is_ht_sym_sort_freq[i*SYM_FREQ_WIDTH +: SYM_FREQ_WIDTH];
              sym_q[i]  <= is_ht_sym_sort_freq_sym[i*DAT_WIDTH +: DAT_WIDTH];
            end
            ptr_q       <= uniq_c;
            uniq_q      <= uniq_c;
            rd_eob_q    <= is_ht_eob;
            rd_meta_q   <= is_ht_meta;
            rd_seq_id_q <= is_ht_seq_id;
            rd_sym_lo_q <= is_ht_sym_lo;
            rd_sym_hi_q <= is_ht_sym_hi;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (fire && rd_last_q) begin
            rd_valid_q    <= 1'b0;
            rd_lane_vld_q <= '0;
            rd_first_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            state_q       <= DRAIN;
          end else if (!rd_valid_q || fire) begin
            ptr_q         <= sel_ptr;
            rd_valid_q    <= 1'b1;
            rd_sym_q      <= nxt_sym;
            rd_freq_q     <= nxt_freq;
            rd_lane_vld_q <= nxt_vld;
            rd_first_q    <= (sel_ptr == uniq_q);
            rd_last_q     <= (sel_ptr + PW'(2)) >= MAXP;
          end
        end
        DRAIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ht_is_not_ready = (state_q != IDLE);
  assign rd_valid        = rd_valid_q;
  assign rd_sym          = rd_sym_q;
  assign rd_freq         = rd_freq_q;
  assign rd_lane_vld     = rd_lane_vld_q;
  assign rd_first        = rd_first_q;
  assign rd_last         = rd_last_q;
  assign rd_eob          = rd_eob_q;
  assign rd_meta         = rd_meta_q;
  assign rd_seq_id       = rd_seq_id_q;
  assign rd_sym_lo       = rd_sym_lo_q;
  assign rd_sym_hi       = rd_sym_hi_q;
  assign rd_err          = rd_err_q;

endmodule

// File: tb/tb_cr_huf_comp_ht_sort_reader.sv
// Directed bench for the sort-table reader: streaming, back-pressure,
// pass-through, busy capture error and mid-stream reset.
module tb_cr_huf_comp_ht_sort_reader;
  import cr_huf_comp_ht_sort_reader_pkg::*;

  localparam int DW = 10;
  localparam int FW = 15;
  localparam int CW = 1;
  localparam int MX = 576;
  localparam int SW = SEQID_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [FW-1:0] tf [MX];
  logic [DW-1:0] ts [MX];
  logic [MX*FW-1:0] freq_bus;
  logic [MX*DW-1:0] sym_bus;

  always_comb begin
    freq_bus = '0;
    sym_bus  = '0;
    for (int i = 0; i < MX; i++) begin
      freq_bus[i*FW +: FW] = tf[i];
      sym_bus[i*DW +: DW]  = ts[i];
    end
  end

  logic [DW-1:0] uniq, lo, hi;
  logic [CW-1:0] meta;
  logic [SW-1:0] seq;
  e_pipe_eob     eob;
  logic          rd_ready;

  logic                   not_ready, rd_valid, rd_first, rd_last, rd_err;
  logic [1:0][DW-1:0]     rd_sym;
  logic [1:0][FW-1:0]     rd_freq;
  logic [1:0]             rd_lane_vld;
  e_pipe_eob              rd_eob;
  logic [CW-1:0]          rd_meta;
  logic [SW-1:0]          rd_seq_id;
  logic [DW-1:0]          rd_sym_lo, rd_sym_hi;

  cr_huf_comp_ht_sort_reader #(
    .DAT_WIDTH(DW), .SYM_FREQ_WIDTH(FW),
    .CNTRL_WIDTH(CW), .MAX_NUM_SYM_USED(MX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .is_ht_sym_sort_freq(freq_bus),
    .is_ht_sym_sort_freq_sym(sym_bus),
    .is_ht_sym_unique(uniq),
    .is_ht_sym_lo(lo), .is_ht_sym_hi(hi),
    .is_ht_meta(meta), .is_ht_seq_id(seq),
    .is_ht_eob(eob),
    .ht_is_not_ready(not_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_sym(rd_sym), .rd_freq(rd_freq),
    .rd_lane_vld(rd_lane_vld),
    .rd_first(rd_first), .rd_last(rd_last),
    .rd_eob(rd_eob), .rd_meta(rd_meta),
    .rd_seq_id(rd_seq_id),
    .rd_sym_lo(rd_sym_lo), .rd_sym_hi(rd_sym_hi),
    .rd_err(rd_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Symbol of entry i is 575-i; freq is 0 below u, else i+1.
  task automatic load_tbl(input int u);
    for (int i = 0; i < MX; i++) begin
      tf[i] = (i < u) ? '0 : FW'(i + 1);
      ts[i] = DW'(575 - i);
    end
  endtask

  task automatic cap(input e_pipe_eob e, input int u);
    eob  = e;
    uniq = DW'(u);
    tick();
    eob  = MIDDLE;
  endtask

  initial begin
    rst_n = 1'b0; uniq = '0; lo = '0; hi = '0; meta = '0; seq = '0;
    eob = MIDDLE; rd_ready = 1'b0;
    load_tbl(0);
    #12;
    chk("rst_valid", rd_valid, 0);
    chk("rst_nrdy", not_ready, 0);
    chk("rst_eob", rd_eob, MIDDLE);
    chk("rst_err", rd_err, 0);
    rst_n = 1'b1;
    tick();

    // unique=572, two full beats
    load_tbl(572);
    tf[572] = 15'd1; tf[573] = 15'd2; tf[574] = 15'd3; tf[575] = 15'd7;
    seq = 8'hA5; meta = 1'b1; lo = 10'd5; hi = 10'd300;
    rd_ready = 1'b1;
    cap(EOB_TRUE, 572);
    chk("t1_nrdy_cap", not_ready, 1);
    chk("t1_valid_cap", rd_valid, 0);
    tick();
    chk("t1_b0_valid", rd_valid, 1);
    chk("t1_b0_sym", {rd_sym[1], rd_sym[0]}, {10'd2, 10'd3});
    chk("t1_b0_freq", {rd_freq[1], rd_freq[0]}, {15'd2, 15'd1});
    chk("t1_b0_fl", {rd_first, rd_last, rd_lane_vld}, 4'b1011);
    chk("t1_seq", rd_seq_id, 8'hA5);
    chk("t1_hi", rd_sym_hi, 10'd300);
    chk("t1_eob", rd_eob, EOB_TRUE);
    tick();
    chk("t1_b1_freq", {rd_freq[1], rd_freq[0]}, {15'd7, 15'd3});
    chk("t1_b1_fl", {rd_valid, rd_first, rd_last, rd_lane_vld}, 5'b10111);
    tick();
    chk("t1_drain", {rd_valid, not_ready}, 2'b01);
    tick();
    chk("t1_idle", not_ready, 0);

    // unique=573, odd tail
    load_tbl(573);
    cap(EOB_TRUE, 573);
    tick();
    chk("t2_b0", {rd_first, rd_last, rd_lane_vld, rd_sym[0], rd_sym[1]},
        {4'b1011, 10'd2, 10'd1});
    tick();
    chk("t2_b1", {rd_valid, rd_first, rd_last, rd_lane_vld}, 5'b10101);
    chk("t2_b1_f0", rd_freq[0], 15'd576);
    tick();
    chk("t2_drain", {rd_valid, not_ready}, 2'b01);
    tick();
    chk("t2_idle", not_ready, 0);

    // pass-through, empty table
    load_tbl(576);
    cap(PASS_THRU, 576);
    tick();
    chk("t3_beat", {rd_valid, rd_first, rd_last, rd_lane_vld}, 5'b11100);
    chk("t3_eob", rd_eob, PASS_THRU);
    tick();
    chk("t3_drain", {rd_valid, not_ready}, 2'b01);
    tick();
    chk("t3_idle", not_ready, 0);

    // back-pressure and busy capture, unique=570
    load_tbl(570);
    rd_ready = 1'b0;
    cap(EOB_MORE, 570);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold", {rd_valid, not_ready, rd_sym[0], rd_freq[0]},
          {2'b11, 10'd5, 15'd571});
      tick();
    end
    rd_ready = 1'b1;
    tick();
    chk("t4_b1", {rd_first, rd_sym[0], rd_freq[1]}, {1'b0, 10'd3, 15'd574});
    cap(EOB_TRUE, 10);
    chk("t4_err", rd_err, 1);
    chk("t4_b2", {rd_last, rd_sym[0], rd_freq[1], rd_lane_vld},
        {1'b1, 10'd1, 15'd576, 2'b11});
    chk("t4_eob", rd_eob, EOB_MORE);
    tick();
    chk("t4_err_clr", rd_err, 0);
    chk("t4_drain", {rd_valid, not_ready}, 2'b01);
    tick();
    chk("t4_idle", not_ready, 0);

    // long stream, reset at beat 100
    load_tbl(0);
    cap(EOB_TRUE, 0);
    tick();
    for (int b = 0; b < 100; b++) begin
      if (b == 0)
        chk("t5_first", {rd_first, rd_sym[0], rd_freq[0]},
            {1'b1, 10'd575, 15'd1});
      if (b == 99)
        chk("t5_b99", {rd_first, rd_last, rd_sym[0], rd_freq[0]},
            {2'b00, 10'd377, 15'd199});
      tick();
    end
    chk("t5_b100", rd_freq[0], 15'd201);
    rst_n = 1'b0;
    #1;
    chk("t5_rst", {rd_valid, not_ready, rd_first, rd_lane_vld, rd_err},
        6'b0);
    chk("t5_rst_sym", {rd_sym, rd_freq}, '0);
    chk("t5_rst_eob", rd_eob, MIDDLE);
    tick();
    rst_n = 1'b1;
    tick();

    // unique beyond table clamps to empty
    cap(EOB_TRUE, 700);
    tick();
    chk("t6_clamp", {rd_valid, rd_first, rd_last, rd_lane_vld}, 5'b11100);
    tick();
    tick();
    chk("t6_idle", not_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
